interrupt_unit: RTL and testbench

Central interrupt arbiter that receives the per-peripheral interrupt request lines (for example TAxINT0/TAxINT1 from each Timer_A) and runs the request/acknowledge handshake with the CPU core. It does four things:
- selects the highest-priority qualified request;
- presents that request's vector address;
- on CPU acknowledge, issues the single-cycle auto-clear pulse for single-source vectors (TAxCLR0 for Timer_A CCR0);
- holds off further arbitration until the CPU reports that the interrupt entry sequence is complete.

---
 rtl/interrupt_unit.sv | 135 +++++++++++++
 tb/tb_interrupt_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_unit.sv
// interrupt_unit
//   Central interrupt arbiter. Qualifies peripheral request lines with GIE
//   (non-maskable lines bypass GIE), picks the lowest-index qualified line,
//   presents its vector, and runs the pend/ack/entry-done handshake with the
//   CPU. Lines flagged in AUTOCLR_MASK receive a one-cycle clear pulse after
//   the acknowledge.
//
// Ports
//   MCLK     system clock, all state on the rising edge
//   reset    asynchronous, active-high reset
//   INTreq   level request lines, line 0 is highest priority
//   GIE      global interrupt enable from SR
//   INTack   CPU accepts the pending interrupt (sampled only while pending)
//   INTdone  CPU finished interrupt entry (sampled only while waiting)
//   INTpend  registered: a qualified interrupt is pending
//   INTvec   registered vector address of the pending/accepted line
//   INTclr   registered one-cycle auto-clear pulses to the peripherals
//   INTbusy  registered: high from acknowledge until INTdone
module interrupt_unit #(
  parameter int unsigned          INT_COUNT    = 8,
  parameter logic [15:0]          VEC_TOP      = 16'hFFFC,
  parameter logic [INT_COUNT-1:0] AUTOCLR_MASK = '0,
  parameter logic [INT_COUNT-1:0] NMI_MASK     = '0
) (
  input  logic                 MCLK,
  input  logic                 reset,
  input  logic [INT_COUNT-1:0] INTreq,
  input  logic                 GIE,
  input  logic                 INTack,
  input  logic                 INTdone,
  output logic                 INTpend,
  output logic [15:0]          INTvec,
  output logic [INT_COUNT-1:0] INTclr,
  output logic                 INTbusy
);

  localparam int unsigned IDX_W = (INT_COUNT > 1) ? $clog2(INT_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK,
    WAIT
  } state_t;

  state_t               state, stateNext;
  logic [IDX_W-1:0]     idx, idxNext;
  logic                 pendNext;
  logic [15:0]          vecNext;
  logic [INT_COUNT-1:0] clrNext;
  logic                 busyNext;

  logic [INT_COUNT-1:0] qual;
  logic                 anyQual;
  logic [IDX_W-1:0]     win;

  function automatic logic [15:0] vecOf(input logic [IDX_W-1:0] i);
    return VEC_TOP - (16'(i) << 1);
  endfunction

  assign qual    = INTreq & ({INT_COUNT{GIE}} | NMI_MASK);
  assign anyQual = |qual;

  // Scan from the lowest-priority line upward so the lowest set index wins.
  always_comb begin
    win = '0;
    for (int unsigned i = INT_COUNT; i > 0; i--) begin
      if (qual[i-1]) win = IDX_W'(i - 1);
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    pendNext  = INTpend;
    vecNext   = INTvec;
    clrNext   = '0;
    busyNext  = INTbusy;
    case (state)
      IDLE: begin
        if (anyQual) begin
          idxNext   = win;
          vecNext   = vecOf(win);
          pendNext  = 1'b1;
          stateNext = PEND;
        end
      end
      PEND: begin
        // Acknowledge takes precedence over withdrawal and re-arbitration,
        // so the vector the CPU accepted is the one it keeps.
        if (INTack) begin
          pendNext  = 1'b0;
          busyNext  = 1'b1;
          stateNext = ACK;
        end else if (!anyQual) begin
          pendNext  = 1'b0;
          stateNext = IDLE;
        end else begin
          idxNext = win;
          vecNext = vecOf(win);
        end
      end
      ACK: begin
        clrNext[idx] = AUTOCLR_MASK[idx];
        stateNext    = WAIT;
      end
      WAIT: begin
        if (INTdone) begin
          busyNext  = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      INTpend <= 1'b0;
      INTvec  <= '0;
      INTclr  <= '0;
      INTbusy <= 1'b0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      INTpend <= pendNext;
      INTvec  <= vecNext;
      INTclr  <= clrNext;
      INTbusy <= busyNext;
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
// tb_interrupt_unit
//   Directed, table-driven bench for interrupt_unit with INT_COUNT = 8,
//   AUTOCLR_MASK = 8'h06 (lines 1 and 2 auto-clear) and NMI_MASK = 8'h01.
//   Each table row gives the inputs held across one rising edge and the
//   outputs expected just after that edge. Asynchronous reset cases are
//   hand-written sequences after the table.
module tb_interrupt_unit;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [7:0]  INTreq;
  logic        GIE;
  logic        INTack;
  logic        INTdone;
  logic        INTpend;
  logic [15:0] INTvec;
  logic [7:0]  INTclr;
  logic        INTbusy;

  int checks = 0;
  int errors = 0;

  interrupt_unit #(
    .INT_COUNT    (8),
    .VEC_TOP      (16'hFFFC),
    .AUTOCLR_MASK (8'h06),
    .NMI_MASK     (8'h01)
  ) dut (
    .MCLK    (MCLK),
    .reset   (reset),
    .INTreq  (INTreq),
    .GIE     (GIE),
    .INTack  (INTack),
    .INTdone (INTdone),
    .INTpend (INTpend),
    .INTvec  (INTvec),
    .INTclr  (INTclr),
    .INTbusy (INTbusy)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    string       name;
    logic [7:0]  req;
    logic        gie;
    logic        ack;
    logic        done;
    logic        pend;
    logic [15:0] vec;
    logic [7:0]  clr;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [7:0] req,
                              input logic gie, input logic ack, input logic done,
                              input logic pend, input logic [15:0] vec,
                              input logic [7:0] clr, input logic busy);
    vec_t v;
    v.name = n; v.req = req; v.gie = gie; v.ack = ack; v.done = done;
    v.pend = pend; v.vec = vec; v.clr = clr; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkAll(input string nm, input logic pend, input logic [15:0] vec,
                          input logic [7:0] clr, input logic busy);
    check({nm, ".pend"}, {15'b0, INTpend}, {15'b0, pend});
    check({nm, ".vec"},  INTvec,           vec);
    check({nm, ".clr"},  {8'b0, INTclr},   {8'b0, clr});
    check({nm, ".busy"}, {15'b0, INTbusy}, {15'b0, busy});
  endtask

  task automatic drive(input logic [7:0] req, input logic gie, input logic ack, input logic done);
    INTreq = req; GIE = gie; INTack = ack; INTdone = done;
  endtask

  initial begin
    //                name          req    gie ack done pend vec       clr    busy
    // Basic handshake on line 2; INTdone two cycles after ack.
    tbl.push_back(mk("idle",       8'h00, 1, 0, 0,   0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk("capture2",   8'h04, 1, 0, 0,   1, 16'hFFF8, 8'h00, 0));
    tbl.push_back(mk("ack2",       8'h04, 1, 1, 0,   0, 16'hFFF8, 8'h00, 1));
    tbl.push_back(mk("clr2",       8'h04, 1, 0, 0,   0, 16'hFFF8, 8'h04, 1));
    tbl.push_back(mk("done2",      8'h04, 1, 0, 1,   0, 16'hFFF8, 8'h00, 0));
    tbl.push_back(mk("recapture2", 8'h04, 1, 0, 0,   1, 16'hFFF8, 8'h00, 0));
    tbl.push_back(mk("withdraw2",  8'h00, 1, 0, 0,   0, 16'hFFF8, 8'h00, 0));
    tbl.push_back(mk("idle2",      8'h00, 1, 0, 0,   0, 16'hFFF8, 8'h00, 0));
    // Preemption in PEND, ack beats same-cycle higher request.
    tbl.push_back(mk("capture4",   8'h10, 1, 0, 0,   1, 16'hFFF4, 8'h00, 0));
    tbl.push_back(mk("preempt1",   8'h12, 1, 0, 0,   1, 16'hFFFA, 8'h00, 0));
    tbl.push_back(mk("ackVs0",     8'h11, 1, 1, 0,   0, 16'hFFFA, 8'h00, 1));
    tbl.push_back(mk("clr1",       8'h11, 1, 0, 0,   0, 16'hFFFA, 8'h02, 1));
    tbl.push_back(mk("waitIgnore", 8'h11, 1, 0, 0,   0, 16'hFFFA, 8'h00, 1));
    tbl.push_back(mk("done1",      8'h11, 1, 0, 1,   0, 16'hFFFA, 8'h00, 0));
    tbl.push_back(mk("capture0",   8'h11, 1, 0, 0,   1, 16'hFFFC, 8'h00, 0));
    tbl.push_back(mk("withdraw0",  8'h00, 1, 0, 0,   0, 16'hFFFC, 8'h00, 0));
    tbl.push_back(mk("ackInIdle",  8'h00, 1, 1, 0,   0, 16'hFFFC, 8'h00, 0));
    // GIE gating and NMI on line 0.
    tbl.push_back(mk("masked1",    8'h02, 0, 0, 0,   0, 16'hFFFC, 8'h00, 0));
    tbl.push_back(mk("nmi0",       8'h03, 0, 0, 0,   1, 16'hFFFC, 8'h00, 0));
    tbl.push_back(mk("doneInPend", 8'h03, 0, 0, 1,   1, 16'hFFFC, 8'h00, 0));
    tbl.push_back(mk("line1Pend",  8'h02, 1, 0, 0,   1, 16'hFFFA, 8'h00, 0));
    tbl.push_back(mk("gieDrop",    8'h02, 0, 0, 0,   0, 16'hFFFA, 8'h00, 0));
    tbl.push_back(mk("staysIdle",  8'h02, 0, 0, 0,   0, 16'hFFFA, 8'h00, 0));

    reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    checkAll("reset", 1'b0, 16'h0000, 8'h00, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].gie, tbl[i].ack, tbl[i].done);
      @(posedge MCLK);
      #1;
      checkAll(tbl[i].name, tbl[i].pend, tbl[i].vec, tbl[i].clr, tbl[i].busy);
    end

    // Reset asserted asynchronously in WAIT clears everything at once.
    drive(8'h04, 1'b1, 1'b0, 1'b0);
    @(posedge MCLK); #1;
    checkAll("seqCap", 1'b1, 16'hFFF8, 8'h00, 1'b0);
    INTack = 1'b1;
    @(posedge MCLK); #1;
    INTack = 1'b0;
    @(posedge MCLK); #1;
    checkAll("seqClr", 1'b0, 16'hFFF8, 8'h04, 1'b1);
    @(posedge MCLK); #2;
    checkAll("seqWait", 1'b0, 16'hFFF8, 8'h00, 1'b1);
    reset = 1'b1;
    #1;
    checkAll("rstWait", 1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    reset = 1'b0;
    drive(8'h01, 1'b1, 1'b0, 1'b0);
    @(posedge MCLK); #1;
    checkAll("postRst", 1'b1, 16'hFFFC, 8'h00, 1'b0);

    // Reset during ACK drops the pending clear pulse for line 1.
    drive(8'h02, 1'b1, 1'b0, 1'b0);
    @(posedge MCLK); #1;
    checkAll("seqCap1", 1'b1, 16'hFFFA, 8'h00, 1'b0);
    INTack = 1'b1;
    @(posedge MCLK); #1;
    INTack = 1'b0;
    checkAll("seqAck1", 1'b0, 16'hFFFA, 8'h00, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkAll("rstAck", 1'b0, 16'h0000, 8'h00, 1'b0);
    @(posedge MCLK); #1;
    checkAll("clrDropped", 1'b0, 16'h0000, 8'h00, 1'b0);
    reset = 1'b0;
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge MCLK); #1;
    checkAll("afterDrop", 1'b0, 16'h0000, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
